// File: rtl/sd_wb_cmd_master.sv
// sd_wb_cmd_master: Wishbone classic single-beat master that issues one SD
// command through the SD controller register slave and reports the outcome.
module sd_wb_cmd_master #(
   parameter int ACK_TIMEOUT = 16,
   parameter int POLL_MAX    = 1024,
   parameter int POLL_GAP    = 4
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   output logic [7:0]  wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   input  logic        req_i,
   input  logic [15:0] cmd_set_i,
   input  logic [31:0] cmd_arg_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] resp_o,
   output logic        err_o,
   output logic [15:0] err_status_o,
   output logic        timeout_o
);

   typedef enum logic [3:0] {
      IDLE, WR_CMD, WR_ARG, POLL, GAP,
      RD_EISR, RD_RESP, CLR_N, CLR_E, DONE
   } state_t;

   localparam logic [7:0]  ACK_LAST = 8'(ACK_TIMEOUT - 1);
   localparam logic [15:0] POLL_LIM = 16'(POLL_MAX);
   localparam logic [7:0]  GAP_LAST = 8'(POLL_GAP);

   state_t      state_q, state_d;
   logic        cyc_q, cyc_d;
   logic [7:0]  ack_cnt_q, ack_cnt_d;
   logic [15:0] poll_cnt_q, poll_cnt_d;
   logic [7:0]  gap_cnt_q, gap_cnt_d;
   logic [15:0] cmd_q, cmd_d;
   logic [31:0] arg_q, arg_d;
   logic [31:0] resp_q, resp_d;
   logic        err_q, err_d;
   logic [15:0] est_q, est_d;
   logic        tmo_q, tmo_d;
   logic        busy_q, busy_d;

   logic        acc;
   logic [7:0]  adr;
   logic        we;
   logic [31:0] wdat;

   // Bus access owned by each state; states without one never raise cyc.
   always_comb begin
      acc  = 1'b1;
      adr  = 8'h00;
      we   = 1'b0;
      wdat = '0;
      unique case (state_q)
         WR_CMD:  begin adr = 8'h04; we = 1'b1; wdat = {16'h0, cmd_q}; end
         WR_ARG:  begin adr = 8'h00; we = 1'b1; wdat = arg_q; end
         POLL:    adr = 8'h30;
         RD_EISR: adr = 8'h34;
         RD_RESP: adr = 8'h0C;
         CLR_N:   begin adr = 8'h30; we = 1'b1; end
         CLR_E:   begin adr = 8'h34; we = 1'b1; end
         default: acc = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      ack_cnt_d  = ack_cnt_q;
      poll_cnt_d = poll_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      cmd_d      = cmd_q;
      arg_d      = arg_q;
      resp_d     = resp_q;
      err_d      = err_q;
      est_d      = est_q;
      tmo_d      = tmo_q;
      busy_d     = busy_q;
      if (acc) begin
         // Each access opens with one idle cycle, keeping cyc low between beats.
         if (!cyc_q) begin
            cyc_d     = 1'b1;
            ack_cnt_d = '0;
         end else if (wb_ack_i) begin
            cyc_d = 1'b0;
            unique case (state_q)
               WR_CMD: state_d = WR_ARG;
               WR_ARG: state_d = POLL;
               POLL: begin
                  if (wb_dat_i[15]) begin
                     state_d = RD_EISR;
                  end else if (wb_dat_i[0]) begin
                     state_d = RD_RESP;
                  end else begin
                     poll_cnt_d = 16'(poll_cnt_q + 16'd1);
                     if (poll_cnt_d == POLL_LIM) begin
                        tmo_d   = 1'b1;
                        state_d = CLR_N;
                     end else begin
                        gap_cnt_d = '0;
                        state_d   = GAP;
                     end
                  end
               end
               RD_EISR: begin
                  est_d   = wb_dat_i[15:0];
                  err_d   = 1'b1;
                  state_d = RD_RESP;
               end
               RD_RESP: begin
                  resp_d  = wb_dat_i;
                  state_d = CLR_N;
               end
               CLR_N: state_d = CLR_E;
               default: begin
                  busy_d  = 1'b0;
                  state_d = DONE;
               end
            endcase
         end else if (ack_cnt_q == ACK_LAST) begin
            cyc_d   = 1'b0;
            tmo_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
         end else begin
            ack_cnt_d = 8'(ack_cnt_q + 8'd1);
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_i) begin
                  cmd_d      = cmd_set_i;
                  arg_d      = cmd_arg_i;
                  resp_d     = '0;
                  err_d      = 1'b0;
                  est_d      = '0;
                  tmo_d      = 1'b0;
                  busy_d     = 1'b1;
                  poll_cnt_d = '0;
                  state_d    = WR_CMD;
               end
            end
            GAP: begin
               if (gap_cnt_q == GAP_LAST) state_d = POLL;
               else gap_cnt_d = 8'(gap_cnt_q + 8'd1);
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q    <= IDLE;
         cyc_q      <= 1'b0;
         ack_cnt_q  <= '0;
         poll_cnt_q <= '0;
         gap_cnt_q  <= '0;
         cmd_q      <= '0;
         arg_q      <= '0;
         resp_q     <= '0;
         err_q      <= 1'b0;
         est_q      <= '0;
         tmo_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cyc_q      <= cyc_d;
         ack_cnt_q  <= ack_cnt_d;
         poll_cnt_q <= poll_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         cmd_q      <= cmd_d;
         arg_q      <= arg_d;
         resp_q     <= resp_d;
         err_q      <= err_d;
         est_q      <= est_d;
         tmo_q      <= tmo_d;
         busy_q     <= busy_d;
      end
   end

   assign wb_cyc_o     = cyc_q;
   assign wb_stb_o     = cyc_q;
   assign wb_sel_o     = cyc_q ? 4'hF : 4'h0;
   assign wb_adr_o     = cyc_q ? adr : 8'h00;
   assign wb_we_o      = cyc_q & we;
   assign wb_dat_o     = cyc_q ? wdat : 32'h0;
   assign busy_o       = busy_q;
   assign done_o       = (state_q == DONE);
   assign resp_o       = resp_q;
   assign err_o        = err_q;
   assign err_status_o = est_q;
   assign timeout_o    = tmo_q;

endmodule
